// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS32 execute stage: multiply/divide opcodes,
// FSM state encodings and default datapath widths.
package pipe_pkg;

    localparam int PIPE_WIDTH = 32;
    localparam int PIPE_RN_W  = 5;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/alu.sv
// Single-cycle ALU shared by the pipeline. Shifts move b by the amount in a;
// lui places the low half of b in the upper half of the result.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic [WIDTH-1:0] r
);
    localparam int SH_W = $clog2(WIDTH);

    // Result selection by function code
    always_comb begin
        r = {WIDTH{1'b0}};
        casez (aluc)
            4'b?000: r = a + b;
            4'b?100: r = a - b;
            4'b?001: r = a & b;
            4'b?101: r = a | b;
            4'b?010: r = a ^ b;
            4'b?110: r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'b0011: r = b << a[SH_W-1:0];
            4'b0111: r = b >> a[SH_W-1:0];
            4'b1111: r = $signed(b) >>> a[SH_W-1:0];
            default: r = {WIDTH{1'b0}};
        endcase
    end
endmodule

// File: rtl/pipe_muldiv.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module pipe_muldiv
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, m_q, m_d, orig_q, orig_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic             sgn_s, a_neg_s, b_neg_s, ge_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s;
    logic [WIDTH:0]   sum_s, rs_s, diff_s;
    logic [2*WIDTH-1:0] prod_s;

    // Operand magnitudes and per-iteration datapath values
    always_comb begin
        sgn_s   = (op == MD_MULT) || (op == MD_DIV);
        a_neg_s = sgn_s & a[WIDTH-1];
        b_neg_s = sgn_s & b[WIDTH-1];
        mag_a_s = a_neg_s ? (~a + ONE_W) : a;
        mag_b_s = b_neg_s ? (~b + ONE_W) : b;
        sum_s   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        rs_s    = {acc_q, quo_q[WIDTH-1]};
        ge_s    = rs_s >= {1'b0, m_q};
        diff_s  = rs_s - {1'b0, m_q};
        prod_s  = neg_q ? (~{acc_q, quo_q} + ONE_2W) : {acc_q, quo_q};
    end

    // Next-state logic for the FSM, iteration registers and HI/LO
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        m_d     = m_q;
        orig_d  = orig_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            state_d = ST_RUN;
                            cnt_d   = CNT_W'(WIDTH - 1);
                            acc_d   = {WIDTH{1'b0}};
                            quo_d   = mag_a_s;
                            m_d     = mag_b_s;
                            orig_d  = a;
                            div_d   = (op == MD_DIV) || (op == MD_DIVU);
                            neg_d   = a_neg_s ^ b_neg_s;
                            rneg_d  = a_neg_s;
                            dz_d    = (b == {WIDTH{1'b0}});
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: hi_d = hi_q;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (div_q) begin
                    acc_d = ge_s ? diff_s[WIDTH-1:0] : rs_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ge_s};
                end else begin
                    acc_d = sum_s[WIDTH:1];
                    quo_d = {sum_s[0], quo_q[WIDTH-1:1]};
                end
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!div_q) begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = orig_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    // The most-negative / -1 case falls out of the magnitude path
                    lo_d = neg_q ? (~quo_q + ONE_W) : quo_q;
                    hi_d = rneg_q ? (~acc_q + ONE_W) : acc_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and HI/LO registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            m_q     <= {WIDTH{1'b0}};
            orig_q  <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            m_q     <= m_d;
            orig_q  <= orig_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != ST_IDLE);
endmodule

// File: rtl/pipe_exe_md.sv
// MIPS32 execute stage: ALU operand/result muxing, JAL link substitution and
// the HI/LO interlock in front of the iterative multiply/divide unit.
module pipe_exe_md
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH,
    parameter int RN_W  = PIPE_RN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       ealuc,
    input  logic             ealuimm,
    input  logic             eshift,
    input  logic             ejal,
    input  logic [3:0]       emdop,
    input  logic             eflush,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic [WIDTH-1:0] eimm,
    input  logic [WIDTH-1:0] epc4,
    input  logic [RN_W-1:0]  ern0,
    output logic [RN_W-1:0]  ern,
    output logic [WIDTH-1:0] ealu,
    output logic             estall,
    output logic             ebusy
);
    logic [WIDTH-1:0] alu_a_s, alu_b_s, alu_r_s, hi_s, lo_s;
    logic             md_valid_s, accept_s;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a    (alu_a_s),
        .b    (alu_b_s),
        .aluc (ealuc),
        .r    (alu_r_s)
    );

    pipe_muldiv #(.WIDTH(WIDTH)) u_md (
        .clock (clock),
        .reset (reset),
        .start (accept_s),
        .op    (emdop),
        .a     (ea),
        .b     (eb),
        .hi    (hi_s),
        .lo    (lo_s),
        .busy  (ebusy)
    );

    // Operand muxes, interlock and result selection
    always_comb begin
        alu_a_s    = eshift  ? eimm : ea;
        alu_b_s    = ealuimm ? eimm : eb;
        md_valid_s = (emdop >= MD_MULT) && (emdop <= MD_MTLO);
        estall     = ebusy & md_valid_s & ~eflush;
        accept_s   = md_valid_s & ~eflush & ~estall;
        ern        = ejal ? {RN_W{1'b1}} : ern0;
        if (ejal) begin
            ealu = epc4;
        end else if (emdop == MD_MFHI) begin
            ealu = hi_s;
        end else if (emdop == MD_MFLO) begin
            ealu = lo_s;
        end else begin
            ealu = alu_r_s;
        end
    end
endmodule

// File: tb/tb_pipe_exe_md.sv
// Directed self-checking bench for pipe_exe_md with hand-computed expectations.
module tb_pipe_exe_md;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  ealuc, emdop;
    logic        ealuimm, eshift, ejal, eflush;
    logic [31:0] ea, eb, eimm, epc4, ealu;
    logic [4:0]  ern0, ern;
    logic        estall, ebusy;
    int          checks = 0;
    int          failures = 0;
    int          n;

    pipe_exe_md #(.WIDTH(32), .RN_W(5)) dut (
        .clock(clock), .reset(reset), .ealuc(ealuc), .ealuimm(ealuimm),
        .eshift(eshift), .ejal(ejal), .emdop(emdop), .eflush(eflush),
        .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0),
        .ern(ern), .ealu(ealu), .estall(estall), .ebusy(ebusy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one mul/div op, then count busy cycles until the unit is idle again
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clock);
        emdop = op; ea = a; eb = b;
        @(negedge clock);
        emdop = 4'd0;
        n = 0;
        while (ebusy && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk(tag, 32'(n), 32'd33);
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        emdop = 4'd5; #1;
        chk({tag, "_hi"}, ealu, exp_hi);
        emdop = 4'd6; #1;
        chk({tag, "_lo"}, ealu, exp_lo);
        emdop = 4'd0;
    endtask

    initial begin
        reset = 1'b1; ealuc = 4'd0; emdop = 4'd0; ealuimm = 1'b0; eshift = 1'b0;
        ejal = 1'b0; eflush = 1'b0; ea = 32'd0; eb = 32'd0; eimm = 32'd0;
        epc4 = 32'd0; ern0 = 5'd0;
        repeat (2) @(negedge clock);
        chk("rst_busy", {31'd0, ebusy}, 32'd0);
        chk("rst_stall", {31'd0, estall}, 32'd0);
        read_hilo("rst", 32'd0, 32'd0);
        reset = 1'b0;

        // ALU path and JAL substitution
        @(negedge clock);
        ea = 32'd5; eimm = 32'd3; ealuimm = 1'b1; ern0 = 5'd7; #1;
        chk("alu_add", ealu, 32'd8);
        chk("alu_ern", {27'd0, ern}, 32'd7);
        ejal = 1'b1; epc4 = 32'h100; #1;
        chk("jal_ealu", ealu, 32'h100);
        chk("jal_ern", {27'd0, ern}, 32'd31);
        ejal = 1'b0; ealuimm = 1'b0;

        run_op(4'd1, 32'hFFFF_FFFD, 32'd7, "mult_busy");
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, "multu_busy");
        read_hilo("multu", 32'd1, 32'hFFFF_FFFE);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div_busy");
        read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(4'd4, 32'd7, 32'd0, "divu0_busy");
        read_hilo("divu0", 32'd7, 32'hFFFF_FFFF);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "divovf_busy");
        read_hilo("divovf", 32'd0, 32'h8000_0000);

        // Interlock: MFLO right behind a MULT stalls until the result lands
        @(negedge clock);
        emdop = 4'd1; ea = 32'd5; eb = 32'd6;
        @(negedge clock);
        emdop = 4'd0; ea = 32'd2; eb = 32'd3; #1;
        chk("add_nostall", {31'd0, estall}, 32'd0);
        chk("add_in_window", ealu, 32'd5);
        emdop = 4'd6; #1;
        chk("mflo_stall", {31'd0, estall}, 32'd1);
        n = 0;
        while (estall && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("stall_len", 32'(n), 32'd33);
        chk("mflo_after", ealu, 32'd30);
        emdop = 4'd0;

        // Flushed DIV must not start; MTHI writes HI at the next edge
        @(negedge clock);
        emdop = 4'd3; ea = 32'd100; eb = 32'd7; eflush = 1'b1;
        @(negedge clock);
        chk("flush_busy", {31'd0, ebusy}, 32'd0);
        emdop = 4'd0; eflush = 1'b0;
        read_hilo("flush", 32'd0, 32'd30);
        @(negedge clock);
        emdop = 4'd7; ea = 32'h1234;
        @(negedge clock);
        read_hilo("mthi", 32'h1234, 32'd30);

        // Reset in the middle of a multiply
        @(negedge clock);
        emdop = 4'd1; ea = 32'd1000; eb = 32'd1000;
        @(negedge clock);
        emdop = 4'd0;
        repeat (9) @(negedge clock);
        chk("mid_busy", {31'd0, ebusy}, 32'd1);
        reset = 1'b1; #1;
        chk("mid_rst_busy", {31'd0, ebusy}, 32'd0);
        read_hilo("mid_rst", 32'd0, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op(4'd1, 32'd2, 32'd3, "fresh_busy");
        read_hilo("fresh", 32'd0, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_exe_md.md
# pipe_exe_md

Parametrised execute stage for the MIPS32 pipeline. It combines the existing single-cycle ALU path (operand muxing, JAL link-address substitution, destination override) with an iterative multiply/divide unit that owns the HI/LO registers. The unit raises an interlock stall toward the pipeline control when a dependent HI/LO instruction reaches EX while an operation is still in flight. It sits between the ID/EX and EX/MEM pipeline registers.

## Interface
- WIDTH, 32: datapath width. Must be even and ≥ 8.
- RN_W, 5: register-number width.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ealuc  in  4  ALU function, same encoding as the existing `alu`.
- ealuimm  in  1  1: ALU B operand = eimm.
- eshift  in  1  1: ALU A operand = eimm (shift amount).
- ejal  in  1  1: result = epc4; destination = all ones.
- emdop  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Others are treated as NONE.
- eflush  in  1  the EX instruction is squashed; it must not start or write anything.
- ea, eb, eimm, epc4  in  WIDTH  operands and link address.
- ern0  in  RN_W  decoded destination register.
- ern  out  RN_W  final destination register.
- ealu  out  WIDTH  stage result.
- estall  out  1  HI/LO interlock request to pipeline control.
- ebusy  out  1  multiply/divide in flight.

## Operation
- ALU path, combinational:
  - A = eshift ? eimm : ea.
  - B = ealuimm ? eimm : eb.
- ealu priority: ejal → epc4; MFHI → HI; MFLO → LO; otherwise ALU out.
- ern = ejal ? all ones : ern0.
- An op is accepted when emdop ≠ NONE, eflush = 0 and estall = 0.
- estall = ebusy & (emdop ∈ 1..8) & ~eflush. It is combinational. Non-HI/LO instructions never stall.
- State machine states: IDLE, RUN, FIX.
  - IDLE: an accepted MULT/MULTU/DIV/DIVU latches its operands and goes to RUN with count = WIDTH−1.
  - MTHI/MTLO in IDLE: write ea into HI or LO at the clock edge ending the accepting cycle.
  - RUN: one iteration per cycle. Multiply is radix-2 shift-add on magnitudes. Divide is restoring on magnitudes. Go to FIX when count = 0.
  - FIX: apply sign correction, write HI/LO, return to IDLE.
- Signed ops take magnitudes of both operands in the start cycle.
  - MULT negates the 2·WIDTH product when the operand signs differ.
  - DIV negates the quotient when the signs differ. The remainder takes the dividend's sign.
- Result placement:
  - MULT/MULTU: HI = product[2W−1:W], LO = product[W−1:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (signed or unsigned): LO = all ones, HI = dividend as issued.
- Signed overflow (−2^(W−1) / −1): LO = −2^(W−1), HI = 0.
- ebusy = (state ≠ IDLE).

## Timing
- Reset values: state IDLE, HI = LO = 0, ebusy = 0, estall = 0. Combinational outputs follow the inputs immediately after reset.
- Reset mid-operation aborts the op and clears HI/LO to 0.
- Latency: start accepted in cycle 0. RUN occupies cycles 1..WIDTH, FIX occupies cycle WIDTH+1. HI/LO update at the end of cycle WIDTH+1. ebusy is high for cycles 1..WIDTH+1.
- An MFHI/MFLO in cycle WIDTH+2 reads the new value without stalling.
- While stalled, inputs are held by the pipeline. The instruction is accepted in the first cycle ebusy = 0.
- eflush during RUN/FIX does not abort the in-flight op. Only the EX-stage instruction is squashed.
- A new start is only possible in IDLE, so back-to-back ops serialize automatically.

## Structure
- Shared package `pipe_pkg`:
  - emdop encodings and the state enum.
  - WIDTH/RN_W defaults.
- Sub-modules:
  - Reuse the existing `alu` unchanged.
  - One new sub-module `pipe_muldiv` holds the FSM, iteration counter, HI/LO and the sign logic.
  - The top level holds the operand muxes, result mux, ern and estall.

## Test plan
- ALU forms: ea=5, eimm=3, ealuimm=1, add ealuc → ealu=8. ejal=1, epc4=0x100 → ealu=0x100, ern=31.
- MULT then wait:
  - ea=−3, eb=7 → after WIDTH+1 busy cycles, MFHI=0xFFFFFFFF and MFLO=0xFFFFFFEB.
  - MULTU 0xFFFFFFFF·2 → HI=1, LO=0xFFFFFFFE.
- DIV:
  - ea=−7, eb=2 → LO=−3, HI=−1.
  - DIVU 7/0 → LO=0xFFFFFFFF, HI=7.
  - DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- Interlock: MFLO issued the cycle after MULT starts → estall=1 for exactly WIDTH+1 cycles, then ealu = new LO. An ADD in the same window is not stalled.
- Flush:
  - DIV with eflush=1 → ebusy stays 0 and HI/LO are unchanged.
  - MTHI ea=0x1234 → HI=0x1234 on the next cycle.
- Reset asserted at RUN cycle 10 → ebusy=0 and HI=LO=0 immediately. A fresh MULT 2·3 then gives LO=6.
